// File: rtl/hack_mem_pkg.sv
// Shared definitions for the Hack data-RAM arbiter slice: bus widths,
// screen map location and the read-response owner encoding.
package hack_mem_pkg;

  localparam int unsigned ADDR_W       = 15;
  localparam int unsigned DATA_W       = 16;
  localparam logic [14:0] SCREEN_BASE  = 15'h4000;
  localparam int unsigned SCREEN_WORDS = 8192;

  // Which master the RAM read data returning next cycle belongs to
  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_CPU  = 2'd1,
    OWNER_VID  = 2'd2
  } owner_e;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating wait counter: counts cycles a pending request is refused and
// flags when the refusal limit has been reached.
module arb_wait_counter #(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int unsigned W = $clog2(MAX + 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins over increment, increment stops at MAX
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !sat) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat = (cnt_q == W'(MAX));

endmodule

// File: rtl/hack_mem_arbiter.sv
// Arbiter sharing the single-port data RAM between the Hack CPU M-port and
// the video scanout engine. Video wins by default; a wait counter forces a
// CPU grant after CPU_MAX_WAIT lost cycles. Read data returns one cycle after
// the grant and is steered to the master recorded in the owner register.
module hack_mem_arbiter #(
  parameter int unsigned ADDR_W       = hack_mem_pkg::ADDR_W,
  parameter int unsigned DATA_W       = hack_mem_pkg::DATA_W,
  parameter int unsigned CPU_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  import hack_mem_pkg::*;

  logic              cpu_sat;
  logic              cpu_inc, cpu_clr;
  owner_e            owner_q, owner_d;
  logic [DATA_W-1:0] cpu_hold_q, vid_hold_q;

  // CPU starvation guard
  arb_wait_counter #(
    .MAX (CPU_MAX_WAIT)
  ) u_wait (
    .clk   (clk),
    .reset (reset),
    .inc   (cpu_inc),
    .clr   (cpu_clr),
    .sat   (cpu_sat)
  );

  // Priority select: video by default, CPU once its wait limit is reached
  always_comb begin
    cpu_gnt = 1'b0;
    vid_gnt = 1'b0;
    if (!reset) begin
      cpu_gnt = cpu_req && (!vid_req || cpu_sat);
      vid_gnt = vid_req && !(cpu_req && cpu_sat);
    end
    cpu_inc = cpu_req && !cpu_gnt;
    cpu_clr = !cpu_req || cpu_gnt;
  end

  // RAM port mux driven by the winner; idle cycles leave the RAM disabled
  always_comb begin
    mem_en    = cpu_gnt || vid_gnt;
    mem_we    = cpu_gnt && cpu_we;
    mem_addr  = cpu_gnt ? cpu_addr : vid_addr;
    mem_wdata = cpu_gnt ? cpu_wdata : '0;
    owner_d   = cpu_gnt ? OWNER_CPU : (vid_gnt ? OWNER_VID : OWNER_NONE);
  end

  // Owner tag and per-master read-data hold registers
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q    <= OWNER_NONE;
      cpu_hold_q <= '0;
      vid_hold_q <= '0;
    end else begin
      owner_q <= owner_d;
      if (owner_q == OWNER_CPU) cpu_hold_q <= mem_rdata;
      if (owner_q == OWNER_VID) vid_hold_q <= mem_rdata;
    end
  end

  // Response demux: RAM data goes straight through to the tagged owner so the
  // completion lands one cycle after the grant; reset masks an in-flight tag.
  always_comb begin
    cpu_rvalid = !reset && (owner_q == OWNER_CPU);
    vid_rvalid = !reset && (owner_q == OWNER_VID);
    cpu_rdata  = reset ? '0 : (cpu_rvalid ? mem_rdata : cpu_hold_q);
    vid_rdata  = reset ? '0 : (vid_rvalid ? mem_rdata : vid_hold_q);
  end

endmodule
